// File: rtl/reg_write_decoder.sv
// 32-entry register file written through a req/ack handshake FSM, with a one-hot write-enable
// decode and a 32-cycle walking clear. Optional macro R0_ZERO_EN makes index 0 read as zero.
module reg_write_decoder #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_REQ,
  input  logic [4:0]            WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  CLR,
  input  logic [4:0]            RD_ADDR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [31:0]           WR_EN_ONEHOT,
  output logic                  WR_ACK,
  output logic                  BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    COMMIT,
    ACK,
    CLEAR
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [4:0]            counter;
  logic [4:0]            counter_nxt;
  logic [4:0]            lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic                  latch_en;
  logic [DATA_WIDTH-1:0] storage [32];

  logic [31:0]           onehot_nxt;
  logic                  ack_nxt;
  logic                  store_en;
  logic                  store_ok;
  logic [4:0]            store_addr;
  logic [DATA_WIDTH-1:0] store_data;

  function automatic logic [31:0] decode(input logic [4:0] idx);
    logic [31:0] d;
    d = 32'd1 << idx;
`ifdef R0_ZERO_EN
    d[0] = 1'b0;
`endif
    return d;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (CLR) begin
          state_nxt = CLEAR;
        end else if (WR_REQ) begin
          state_nxt = DECODE;
        end
      end
      DECODE: state_nxt = COMMIT;
      COMMIT: state_nxt = ACK;
      ACK: begin
        if (!WR_REQ) begin
          state_nxt = IDLE;
        end
      end
      CLEAR: begin
        if (counter == 5'd31) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and the storage write port.
  always_comb begin
    onehot_nxt  = '0;
    ack_nxt     = 1'b0;
    store_en    = 1'b0;
    store_addr  = lat_addr;
    store_data  = lat_data;
    counter_nxt = counter;
    latch_en    = 1'b0;
    case (state)
      IDLE: begin
        if (CLR) begin
          counter_nxt = 5'd0;
        end else if (WR_REQ) begin
          latch_en = 1'b1;
        end
      end
      DECODE: onehot_nxt = decode(lat_addr);
      COMMIT: begin
        store_en = 1'b1;
        ack_nxt  = 1'b1;
      end
      ACK: ack_nxt = WR_REQ;
      CLEAR: begin
        store_en    = 1'b1;
        store_addr  = counter;
        store_data  = RESET_VALUE;
        onehot_nxt  = decode(counter);
        counter_nxt = counter + 5'd1;
      end
      default: begin
        onehot_nxt = '0;
      end
    endcase
  end

`ifdef R0_ZERO_EN
  assign store_ok = store_en && (store_addr != 5'd0);
  assign RD_DATA  = (RD_ADDR == 5'd0) ? '0 : storage[RD_ADDR];
`else
  assign store_ok = store_en;
  assign RD_DATA  = storage[RD_ADDR];
`endif

  // Reset wipes every word so an aborted write or clear leaves nothing behind.
  always_ff @(posedge CLK) begin
    if (RST) begin
      counter      <= 5'd0;
      lat_addr     <= 5'd0;
      lat_data     <= '0;
      WR_EN_ONEHOT <= '0;
      WR_ACK       <= 1'b0;
      BUSY         <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        storage[i] <= RESET_VALUE;
      end
    end else begin
      counter      <= counter_nxt;
      WR_EN_ONEHOT <= onehot_nxt;
      WR_ACK       <= ack_nxt;
      BUSY         <= (state_nxt != IDLE);
      if (latch_en) begin
        lat_addr <= WR_ADDR;
        lat_data <= WR_DATA;
      end
      if (store_ok) begin
        storage[store_addr] <= store_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_decoder.sv
// Randomized and directed bench for reg_write_decoder, checked every cycle against a
// transaction-age reference model; honours R0_ZERO_EN when it is defined.
module tb_reg_write_decoder;

`ifdef R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WR_REQ = 1'b0;
  logic [4:0]  WR_ADDR = '0;
  logic [31:0] WR_DATA = '0;
  logic        CLR = 1'b0;
  logic [4:0]  RD_ADDR = '0;
  logic [31:0] RD_DATA;
  logic [31:0] WR_EN_ONEHOT;
  logic        WR_ACK;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  reg_write_decoder dut (
    .CLK          (CLK),
    .RST          (RST),
    .WR_REQ       (WR_REQ),
    .WR_ADDR      (WR_ADDR),
    .WR_DATA      (WR_DATA),
    .CLR          (CLR),
    .RD_ADDR      (RD_ADDR),
    .RD_DATA      (RD_DATA),
    .WR_EN_ONEHOT (WR_EN_ONEHOT),
    .WR_ACK       (WR_ACK),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference model: an operation is tracked by how many edges have passed since it was sampled.
  int          mode = 0;
  int          age = 0;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_mem [32];
  logic [31:0] exp_oh = '0;
  logic        exp_ack = 1'b0;
  logic        exp_busy = 1'b0;
  bit          model_valid = 1'b0;

  function automatic logic [31:0] ohOf(input int i);
    logic [31:0] v;
    v = '0;
    if (!(R0 && i == 0)) v[i] = 1'b1;
    return v;
  endfunction

  task automatic modelStep();
    if (RST) begin
      mode = 0;
      age = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
      exp_oh = '0;
      exp_ack = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (mode == 0) begin
        exp_oh = '0;
        exp_ack = 1'b0;
        if (CLR) begin
          mode = 2;
          age = 0;
        end else if (WR_REQ) begin
          mode = 1;
          age = 0;
          m_addr = WR_ADDR;
          m_data = WR_DATA;
        end
      end else if (mode == 1) begin
        age++;
        if (age == 1) begin
          exp_oh = ohOf(int'(m_addr));
        end else if (age == 2) begin
          exp_oh = '0;
          exp_ack = 1'b1;
          if (!(R0 && m_addr == 5'd0)) m_mem[m_addr] = m_data;
        end else if (!WR_REQ) begin
          exp_ack = 1'b0;
          mode = 0;
        end
      end else begin
        age++;
        if (!(R0 && age == 1)) m_mem[age-1] = '0;
        exp_oh = ohOf(age - 1);
        if (age == 32) mode = 0;
      end
    end
    exp_busy = (mode != 0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic clr, input logic req,
                               input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
    RST = rst;
    CLR = clr;
    WR_REQ = req;
    WR_ADDR = wa;
    WR_DATA = wd;
    RD_ADDR = ra;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic readCheck(input string name, input logic [4:0] a, input logic [31:0] expected);
    RD_ADDR = a;
    #1;
    checkOutput(name, RD_DATA, expected);
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [31:0] d);
    int n;
    applyStimulus(1'b0, 1'b0, 1'b1, a, d, RD_ADDR);
    n = 0;
    do begin
      tick();
      n++;
    end while (!WR_ACK && n < 20);
    checkOutput("wr_ack_latency", n, 3);
    WR_REQ = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (BUSY && n < 20);
    checkOutput("write_back_idle", {31'b0, BUSY}, 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (model_valid) begin
        checkOutput("model_onehot", WR_EN_ONEHOT, exp_oh);
        checkOutput("model_ack", {31'b0, WR_ACK}, {31'b0, exp_ack});
        checkOutput("model_busy", {31'b0, BUSY}, {31'b0, exp_busy});
        checkOutput("model_rd_data", RD_DATA,
                    (R0 && RD_ADDR == 5'd0) ? 32'd0 : m_mem[RD_ADDR]);
        checkOutput("onehot_popcount_le1", {31'b0, $countones(WR_EN_ONEHOT) <= 1}, 32'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt;
    int n;

    // Reset held two cycles, then every word must read the reset value.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
    tick();
    tick();
    RST = 1'b0;
    checkOutput("reset_busy", {31'b0, BUSY}, 32'd0);
    checkOutput("reset_ack", {31'b0, WR_ACK}, 32'd0);
    checkOutput("reset_onehot", WR_EN_ONEHOT, 32'd0);
    for (int i = 0; i < 32; i++) readCheck("reset_sweep", 5'(i), 32'd0);

    // Basic write to index 0x13 with cycle-exact checks.
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h13, 32'h1004_1004, 5'h13);
    tick();
    checkOutput("w13_busy_k", {31'b0, BUSY}, 32'd1);
    checkOutput("w13_onehot_k", WR_EN_ONEHOT, 32'd0);
    tick();
    checkOutput("w13_onehot_k1", WR_EN_ONEHOT, 32'h0008_0000);
    checkOutput("w13_ack_k1", {31'b0, WR_ACK}, 32'd0);
    readCheck("w13_no_bypass", 5'h13, 32'd0);
    tick();
    checkOutput("w13_onehot_k2", WR_EN_ONEHOT, 32'd0);
    checkOutput("w13_ack_k2", {31'b0, WR_ACK}, 32'd1);
    readCheck("w13_read", 5'h13, 32'h1004_1004);
    tick();
    checkOutput("w13_ack_held", {31'b0, WR_ACK}, 32'd1);
    WR_REQ = 1'b0;
    tick();
    checkOutput("w13_ack_drop", {31'b0, WR_ACK}, 32'd0);
    checkOutput("w13_busy_drop", {31'b0, BUSY}, 32'd0);

    // Clear beats a simultaneous write request; the write is serviced afterwards.
    doWrite(5'd14, 32'hffff_ffff);
    readCheck("w14_read", 5'd14, 32'hffff_ffff);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd14);
    tick();
    CLR = 1'b0;
    busy_cnt = BUSY ? 1 : 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      checkOutput("clear_walk", WR_EN_ONEHOT, (R0 && i == 0) ? 32'd0 : (32'd1 << i));
      if (BUSY) busy_cnt++;
    end
    checkOutput("clear_busy_cycles", busy_cnt, 32);
    readCheck("clear_w14", 5'd14, 32'd0);
    readCheck("clear_w13", 5'h13, 32'd0);
    n = 0;
    while (!WR_ACK && n < 20) begin
      tick();
      n++;
    end
    checkOutput("pending_write_ack", {31'b0, WR_ACK}, 32'd1);
    WR_REQ = 1'b0;
    tick();
    readCheck("pending_write_read", 5'd7, 32'h1234_5678);

    // Index 0 write: ordinary word, or hard zero when R0_ZERO_EN is defined.
    doWrite(5'd0, 32'haaaa_aaaa);
    readCheck("r0_read", 5'd0, R0 ? 32'd0 : 32'haaaa_aaaa);

    // Reset during COMMIT aborts the write.
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd4, 32'h5555_5555, 5'd4);
    tick();
    tick();
    RST = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4);
    checkOutput("rst_commit_onehot", WR_EN_ONEHOT, 32'd0);
    checkOutput("rst_commit_ack", {31'b0, WR_ACK}, 32'd0);
    checkOutput("rst_commit_busy", {31'b0, BUSY}, 32'd0);
    readCheck("rst_commit_w4", 5'd4, 32'd0);
    readCheck("rst_commit_w7", 5'd7, 32'd0);

    // Reset at counter=10 of a clear.
    doWrite(5'd20, 32'hdead_beef);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd20);
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("rst_clear_onehot", WR_EN_ONEHOT, 32'd0);
    checkOutput("rst_clear_busy", {31'b0, BUSY}, 32'd0);
    readCheck("rst_clear_w20", 5'd20, 32'd0);

    // Address/data change after the sampling edge must not redirect the write.
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h02, 32'h0bad_f00d, 5'h02);
    tick();
    WR_ADDR = 5'h1f;
    WR_DATA = 32'h7777_7777;
    tick();
    tick();
    checkOutput("late_addr_ack", {31'b0, WR_ACK}, 32'd1);
    WR_REQ = 1'b0;
    tick();
    readCheck("late_addr_w2", 5'h02, 32'h0bad_f00d);
    readCheck("late_addr_w31", 5'h1f, 32'd0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 24) == 0),
                    ($urandom_range(0, 2) != 0),
                    5'($urandom_range(0, 31)),
                    $urandom,
                    5'($urandom_range(0, 31)));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
    n = 0;
    while (BUSY && n < 40) begin
      tick();
      n++;
    end
    checkOutput("final_idle", {31'b0, BUSY}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
